// File: rtl/count_monitor_pkg.sv
// Shared types and step classification for the count bus monitor.
package count_monitor_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      UP       = 2'd1,
      DOWN     = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DN   = 2'd2,
      STEP_ERR  = 2'd3
   } step_e;

   // delta is (new - ref), only the low `bits` bits are meaningful
   function automatic step_e classify_step(input logic [31:0] delta,
                                           input int bits);
      logic [31:0] mask;
      logic [31:0] d;
      mask = (32'd1 << bits) - 32'd1;
      d    = delta & mask;
      if (d == 32'd0)
         return STEP_NONE;
      else if (d == 32'd1)
         return STEP_UP;
      else if (d == mask)
         return STEP_DN;
      else
         return STEP_ERR;
   endfunction

endpackage

// File: rtl/count_monitor_filter.sv
// Synchronizer, stability filter and accept strobe for the count bus.
// Gray-to-binary conversion is enabled by COUNT_MONITOR_GRAY_EN.
import count_monitor_pkg::*;

module count_monitor_filter #(
   parameter int BITS       = 4,
   parameter int STABLE_CYC = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_clr,
   input  logic [BITS-1:0] i_count,
   output logic            o_acc,
   output logic [BITS-1:0] o_val
);

   localparam logic [3:0] SC = 4'(STABLE_CYC);

   logic [BITS-1:0] r_s1;
   logic [BITS-1:0] r_s2;
   logic            r_s1_vld;
   logic            r_s2_vld;
   logic [BITS-1:0] r_cand;
   logic            r_cand_vld;
   logic [3:0]      r_stab;
   logic [BITS-1:0] r_last;
   logic            r_last_vld;
   logic [BITS-1:0] w_bin;
   logic [3:0]      w_stab_nxt;

`ifdef COUNT_MONITOR_GRAY_EN
   always_comb begin
      w_bin = '0;
      for (int i = 0; i < BITS; i++)
         w_bin[i] = ^(r_s2 >> i);
   end
`else
   assign w_bin = r_s2;
`endif

   // Valid bits keep reset-cleared flops from being accepted as a value
   always_comb begin
      w_stab_nxt = 4'd0;
      if (r_s2_vld) begin
         if (!r_cand_vld || w_bin != r_cand)
            w_stab_nxt = 4'd1;
         else if (r_stab != SC)
            w_stab_nxt = r_stab + 4'd1;
         else
            w_stab_nxt = r_stab;
      end
   end

   assign o_acc = r_s2_vld && (w_stab_nxt == SC) &&
                  (!r_last_vld || w_bin != r_last);
   assign o_val = w_bin;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1       <= '0;
         r_s2       <= '0;
         r_s1_vld   <= 1'b0;
         r_s2_vld   <= 1'b0;
         r_cand     <= '0;
         r_cand_vld <= 1'b0;
         r_stab     <= 4'd0;
         r_last     <= '0;
         r_last_vld <= 1'b0;
      end else begin
         r_s1       <= i_count;
         r_s1_vld   <= 1'b1;
         r_s2       <= r_s1;
         r_s2_vld   <= r_s1_vld;
         r_cand     <= w_bin;
         r_cand_vld <= r_s2_vld;
         r_stab     <= w_stab_nxt;
         if (i_clr) begin
            r_last_vld <= 1'b0;
         end else if (o_acc) begin
            r_last     <= w_bin;
            r_last_vld <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/count_monitor.sv
// Up/down count bus monitor: position, direction and illegal-jump tracking.
// Optional Gray-coded input via COUNT_MONITOR_GRAY_EN (see filter).
import count_monitor_pkg::*;

module count_monitor #(
   parameter int BITS       = 4,
   parameter int STABLE_CYC = 2,
   parameter int POS_W      = 16,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [BITS-1:0]  count_in,
   output logic [POS_W-1:0] pos,
   output logic             dir,
   output logic             locked,
   output logic             step_pulse,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
   localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   state_e           r_state;
   logic [BITS-1:0]  r_ref;
   logic [POS_W-1:0] r_pos;
   logic             r_dir;
   logic             r_locked;
   logic             r_step;
   logic             r_errp;
   logic [ERR_W-1:0] r_err;
   logic             w_acc;
   logic [BITS-1:0]  w_val;
   logic [BITS-1:0]  w_delta;
   step_e            w_cls;

   count_monitor_filter #(
      .BITS       (BITS),
      .STABLE_CYC (STABLE_CYC)
   ) u_filter (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clr   (clr),
      .i_count (count_in),
      .o_acc   (w_acc),
      .o_val   (w_val)
   );

   assign w_delta = w_val - r_ref;
   assign w_cls   = classify_step(32'(w_delta), BITS);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= UNLOCKED;
         r_ref    <= '0;
         r_pos    <= '0;
         r_dir    <= 1'b1;
         r_locked <= 1'b0;
         r_step   <= 1'b0;
         r_errp   <= 1'b0;
         r_err    <= '0;
      end else begin
         r_step <= 1'b0;
         r_errp <= 1'b0;
         if (clr) begin
            r_state  <= UNLOCKED;
            r_locked <= 1'b0;
            r_pos    <= '0;
            r_err    <= '0;
         end else if (w_acc) begin
            r_ref <= w_val;
            if (r_state == UNLOCKED) begin
               r_state  <= UP;
               r_locked <= 1'b1;
            end else begin
               unique case (w_cls)
                  STEP_UP: begin
                     if (r_pos != POS_MAX)
                        r_pos <= r_pos + 1'b1;
                     r_dir   <= 1'b1;
                     r_state <= UP;
                     r_step  <= 1'b1;
                  end
                  STEP_DN: begin
                     if (r_pos != POS_MIN)
                        r_pos <= r_pos - 1'b1;
                     r_dir   <= 1'b0;
                     r_state <= DOWN;
                     r_step  <= 1'b1;
                  end
                  STEP_ERR: begin
                     if (r_err != ERR_MAX)
                        r_err <= r_err + 1'b1;
                     r_errp <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign pos        = r_pos;
   assign dir        = r_dir;
   assign locked     = r_locked;
   assign step_pulse = r_step;
   assign err_pulse  = r_errp;
   assign err_cnt    = r_err;

endmodule

// File: tb/tb_count_monitor.sv
// Directed self-checking bench for count_monitor (default build).
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_count_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [3:0]  count_in;
   logic [15:0] pos;
   logic        dir;
   logic        locked;
   logic        step_pulse;
   logic        err_pulse;
   logic [7:0]  err_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int n_step = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   count_monitor #(
      .BITS       (4),
      .STABLE_CYC (2),
      .POS_W      (16),
      .ERR_W      (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .count_in   (count_in),
      .pos        (pos),
      .dir        (dir),
      .locked     (locked),
      .step_pulse (step_pulse),
      .err_pulse  (err_pulse),
      .err_cnt    (err_cnt)
   );

   always @(negedge clk) begin
      if (step_pulse) n_step++;
      if (err_pulse) n_err++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic relock(input logic [3:0] v, input string tag);
      count_in = v;
      clr = 1'b1;
      step(6);
      chk({tag, "_clr_locked"}, 32'(locked), 32'd0);
      chk({tag, "_clr_pos"}, 32'(pos), 32'd0);
      clr = 1'b0;
      step(1);
      chk({tag, "_relocked"}, 32'(locked), 32'd1);
   endtask

   int ns;
   int ne;
   logic [3:0] v;

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      count_in = 4'd5;
      step(3);
      chk("rst_pos", 32'(pos), 32'd0);
      chk("rst_dir", 32'(dir), 32'd1);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      chk("rst_pulses", 32'({step_pulse, err_pulse}), 32'd0);
      rst = 1'b0;

      step(3);
      chk("lock_early", 32'(locked), 32'd0);
      step(1);
      chk("lock_4cyc", 32'(locked), 32'd1);
      chk("lock_pos", 32'(pos), 32'd0);
      chk("lock_nopulse", 32'(n_step + n_err), 32'd0);

      count_in = 4'd6;
      step(3);
      chk("up1_early", 32'(step_pulse), 32'd0);
      step(1);
      chk("up1_pulse", 32'(step_pulse), 32'd1);
      chk("up1_pos", 32'(pos), 32'd1);
      chk("up1_dir", 32'(dir), 32'd1);
      step(1);
      chk("up1_onecyc", 32'(step_pulse), 32'd0);
      step(1);
      count_in = 4'd7;
      step(4);
      chk("up2_pulse", 32'(step_pulse), 32'd1);
      chk("up2_pos", 32'(pos), 32'd2);
      step(2);
      chk("up_count", 32'(n_step), 32'd2);

      relock(4'd15, "l15");
      count_in = 4'd0;
      step(4);
      chk("wrap_up_pulse", 32'(step_pulse), 32'd1);
      chk("wrap_up_pos", 32'(pos), 32'd1);
      chk("wrap_up_dir", 32'(dir), 32'd1);
      step(2);
      count_in = 4'd15;
      step(4);
      chk("wrap_dn_pulse", 32'(step_pulse), 32'd1);
      chk("wrap_dn_pos", 32'(pos), 32'd0);
      chk("wrap_dn_dir", 32'(dir), 32'd0);
      chk("wrap_err", 32'(err_cnt), 32'd0);
      step(2);

      relock(4'd3, "l3");
      count_in = 4'd9;
      step(4);
      chk("jump_errp", 32'(err_pulse), 32'd1);
      chk("jump_step", 32'(step_pulse), 32'd0);
      chk("jump_errcnt", 32'(err_cnt), 32'd1);
      chk("jump_pos", 32'(pos), 32'd0);
      step(2);
      count_in = 4'd10;
      step(4);
      chk("after_jump_step", 32'(step_pulse), 32'd1);
      chk("after_jump_pos", 32'(pos), 32'd1);
      chk("after_jump_dir", 32'(dir), 32'd1);
      step(2);

      relock(4'd4, "l4");
      ns = n_step;
      ne = n_err;
      count_in = 4'd12;
      step(1);
      count_in = 4'd4;
      step(8);
      chk("glitch_step", 32'(n_step - ns), 32'd0);
      chk("glitch_err", 32'(n_err - ne), 32'd0);

      count_in = 4'd5;
      step(3);
      clr = 1'b1;
      step(1);
      chk("clr_acc_step", 32'(step_pulse), 32'd0);
      chk("clr_acc_pos", 32'(pos), 32'd0);
      chk("clr_acc_err", 32'(err_cnt), 32'd0);
      chk("clr_acc_locked", 32'(locked), 32'd0);
      clr = 1'b0;
      step(1);
      chk("clr_relock", 32'(locked), 32'd1);
      chk("clr_relock_pos", 32'(pos), 32'd0);
      count_in = 4'd6;
      step(4);
      chk("clr_ref5_step", 32'(step_pulse), 32'd1);
      chk("clr_ref5_pos", 32'(pos), 32'd1);
      step(2);

      relock(4'd0, "l0");
      ns = n_step;
      v = 4'd0;
      for (int i = 0; i < 32770; i++) begin
         v = v + 4'd1;
         count_in = v;
         step(2);
      end
      step(4);
      chk("sat_pos", 32'(pos), 32'h7fff);
      chk("sat_steps", 32'(n_step - ns), 32'd32770);
      v = v - 4'd1;
      count_in = v;
      step(4);
      chk("sat_down", 32'(pos), 32'h7ffe);
      step(2);

      ne = n_err;
      for (int i = 0; i < 300; i++) begin
         v = v ^ 4'd8;
         count_in = v;
         step(2);
      end
      step(4);
      chk("errsat_cnt", 32'(err_cnt), 32'd255);
      chk("errsat_pulses", 32'(n_err - ne), 32'd300);
      chk("errsat_pos", 32'(pos), 32'h7ffe);

      rst = 1'b1;
      clr = 1'b1;
      step(1);
      chk("rst_over_clr_err", 32'(err_cnt), 32'd0);
      chk("rst_over_clr_dir", 32'(dir), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Receiving end of the team's up/down counter output: samples an asynchronous BITS-wide count bus from an external counter.
- Filters the bus, decodes each stable change as an up step, a down step or an illegal jump, and keeps a signed position accumulator, direction flag and error counter.
- Sits beside the counter in the top wrapper, driven from the dedicated inputs; results go to the dedicated outputs.

Parameters:
BITS, 4, width of observed count bus
STABLE_CYC, 2, consecutive equal synchronized samples required to accept a value (range 1..15)
POS_W, 16, width of signed position accumulator
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
clr  input  1  synchronous clear of pos/err_cnt/lock; filter keeps running
count_in  input  BITS  asynchronous count bus from external counter
pos  output  POS_W  signed accumulated position
dir  output  1  last legal step direction: 1 = up, 0 = down
locked  output  1  reference value held (FSM not UNLOCKED)
step_pulse  output  1  one-cycle pulse per legal step
err_pulse  output  1  one-cycle pulse per illegal jump
err_cnt  output  ERR_W  number of illegal jumps, saturating

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: pos=0, dir=1, locked=0, step_pulse=0, err_pulse=0, err_cnt=0. Sync flops, filter and ref cleared; last-accepted marked invalid.
- Synchronizer: 2-FF on count_in, producing s2.
- Filter:
  - cand tracks s2.
  - stab_cnt resets to 1 when s2 != cand, otherwise increments, saturating at STABLE_CYC.
  - A value is accepted for one cycle when stab_cnt reaches STABLE_CYC and cand differs from last-accepted, or last-accepted is invalid.
- Latency: count_in settles before edge k → step_pulse/err_pulse high in the cycle after edge k+1+STABLE_CYC. Glitches shorter than STABLE_CYC cycles produce no event.
- FSM states: UNLOCKED, UP, DOWN.
  - UNLOCKED + accept v: ref<=v, go UP, locked=1, no pulse, pos unchanged.
  - UP/DOWN + accept v: delta=(v-ref) mod 2^BITS.
  - delta==1: step up, pos+1, dir=1, state UP, step_pulse.
  - delta==2^BITS-1: step down, pos-1, dir=0, state DOWN, step_pulse.
  - Any other delta: err_pulse, err_cnt+1, pos unchanged, state and dir unchanged.
  - In all three cases ref<=v.
- Wrap-around: 15→0 is up, 0→15 is down (BITS=4). Reversal UP↔DOWN is legal.
- Arithmetic:
  - pos is two's complement and saturates at +2^(POS_W-1)-1 / -2^(POS_W-1).
  - step_pulse still fires while saturated.
  - err_cnt saturates at all-ones; err_pulse still fires.
- clr:
  - Effect: pos=0, err_cnt=0, state UNLOCKED, locked=0, last-accepted invalidated.
  - clr beats a simultaneous accept: that accept is discarded.
  - The current stable value is re-accepted as ref on the first cycle after clr with stab_cnt==STABLE_CYC.
- rst beats clr. rst mid-operation aborts any pending filter count.
- Outputs are registered; pulses are never longer than one cycle.

Optional Feature:
- Macro COUNT_MONITOR_GRAY_EN.
- Defined: s2 is treated as Gray code and converted to binary before the filter, so ref/delta logic runs on binary values; a Gray-coded counter is then tracked glitch-free with STABLE_CYC=1.
- Undefined: count_in is treated as plain binary with no conversion logic.

Decomposition:
- Package count_monitor_pkg:
  - state enum (UNLOCKED, UP, DOWN);
  - step-class enum (STEP_NONE, STEP_UP, STEP_DN, STEP_ERR);
  - helper function for modular delta classification.
- Sub-module count_monitor_filter: 2-FF synchronizer, optional Gray conversion, stability counter and accept strobe with accepted value. Parent holds FSM, pos and err_cnt.

Test Plan (BITS=4, STABLE_CYC=2, POS_W=16, ERR_W=8):
- rst, then count_in held at 5 → locked=1 after 4 cycles, pos=0, no pulses.
- 5→6→7, each held 6 cycles → two step_pulses, pos=2, dir=1; first pulse 4 cycles after change.
- Locked at 15: 15→0 then 0→15 → pos +1 then back, dir=1 then 0, err_cnt=0.
- Locked at 3, jump to 9 → err_pulse, err_cnt=1, pos unchanged, ref=9; next 9→10 → legal up step.
- 1-cycle glitch 4→12→4 → no step/err pulse; assert clr during an accept cycle → pos=0, err_cnt=0, locked=0, relock on held value within 2 cycles.
- Drive 32770 up steps from pos=0 → pos sticks at 32767 with step_pulse each step; 300 illegal jumps → err_cnt=255.
